// File: rtl/uart_xcvr_param.sv
// uart_xcvr_param: parametrised full-duplex UART with TX/RX FIFOs (valid/ready).
// Define UART_PARITY_EN to add a parity bit to every frame (sense set by PARITY_ODD).
module uart_xcvr_param #(
  parameter int CLK_DIV    = 868,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic                 txd,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_parity_err
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_MID = DW'(CLK_DIV / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic ODD = PARITY_ODD != 0;
`ifdef UART_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4;
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic tx_empty, tx_full, tx_push, tx_pop, tx_end;
  logic rx_empty, rx_full, rx_push, rx_pop, rx_end;
  logic [2:0] tx_st, rx_st;
  logic [DW-1:0] tx_div, rx_div;
  logic [BW-1:0] tx_bit, rx_bit;
  logic [DATA_BITS-1:0] tx_sh, rx_sh, tx_head;
  logic tx_par, rx_s1, rx_s2, rx_prev, rx_perr;
  assign tx_empty = tx_wp == tx_rp;
  assign tx_full = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
  assign rx_empty = rx_wp == rx_rp;
  assign rx_full = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
  assign tx_ready = !tx_full;
  assign tx_push = tx_valid && !tx_full;
  assign tx_end = tx_div == DIV_LAST;
  assign tx_pop = !tx_empty && (tx_st == IDLE || (tx_st == STOP && tx_end));
  assign tx_head = tx_mem[tx_rp[AW-1:0]];
  assign tx_busy = !tx_empty || tx_st != IDLE;
  assign rx_valid = !rx_empty;
  assign rx_pop = rx_ready && !rx_empty;
  assign rx_end = rx_div == DIV_LAST;
  assign rx_push = rx_st == STOP && rx_end && rx_s2 && (!rx_full || rx_pop);
  assign rx_data = rx_empty ? '0 : rx_mem[rx_rp[AW-1:0]];
  assign rx_parity_err = PAR_EN && rx_perr;
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= tx_data;
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_sh;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop) tx_rp <= tx_rp + 1'b1;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop) rx_rp <= rx_rp + 1'b1;
    end
  end
  // a pop at the end of STOP chains straight into the next START
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st <= IDLE;
      tx_div <= '0;
      tx_bit <= '0;
      tx_sh <= '0;
      tx_par <= 1'b0;
      txd <= 1'b1;
    end else if (tx_pop) begin
      tx_st <= START;
      tx_div <= '0;
      tx_sh <= tx_head;
      tx_par <= ^tx_head ^ ODD;
      txd <= 1'b0;
    end else if (tx_st != IDLE) begin
      tx_div <= tx_end ? '0 : tx_div + 1'b1;
      if (tx_end) begin
        if (tx_st == START) begin
          tx_st <= DATA;
          txd <= tx_sh[0];
        end else if (tx_st == DATA) begin
          tx_sh <= tx_sh >> 1;
          tx_bit <= tx_bit == BIT_LAST ? '0 : tx_bit + 1'b1;
          tx_st <= tx_bit == BIT_LAST ? (PAR_EN ? PARITY : STOP) : DATA;
          txd <= tx_bit == BIT_LAST ? (PAR_EN ? tx_par : 1'b1) : tx_sh[1];
        end else if (tx_st == PARITY) begin
          tx_st <= STOP;
          txd <= 1'b1;
        end else tx_st <= IDLE;
      end
    end
  end
  // re-arming needs a fresh 1->0 edge, so a low line after a bad stop bit is ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_prev <= 1'b1;
      rx_st <= IDLE;
      rx_div <= '0;
      rx_bit <= '0;
      rx_sh <= '0;
      rx_frame_err <= 1'b0;
      rx_overrun <= 1'b0;
      rx_perr <= 1'b0;
    end else begin
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
      rx_prev <= rx_s2;
      rx_frame_err <= 1'b0;
      rx_overrun <= 1'b0;
      rx_perr <= 1'b0;
      rx_div <= (rx_st == IDLE || rx_end) ? '0 : rx_div + 1'b1;
      if (rx_st == IDLE) begin
        if (rx_prev && !rx_s2) rx_st <= START;
      end else if (rx_st == START) begin
        if (rx_div == DIV_MID) begin
          rx_st <= rx_s2 ? IDLE : DATA;
          rx_div <= '0;
        end
      end else if (rx_end) begin
        if (rx_st == DATA) begin
          rx_sh <= {rx_s2, rx_sh[DATA_BITS-1:1]};
          rx_bit <= rx_bit == BIT_LAST ? '0 : rx_bit + 1'b1;
          rx_st <= rx_bit == BIT_LAST ? (PAR_EN ? PARITY : STOP) : DATA;
        end else if (rx_st == PARITY) begin
          rx_perr <= rx_s2 != (^rx_sh ^ ODD);
          rx_st <= rx_s2 != (^rx_sh ^ ODD) ? IDLE : STOP;
        end else begin
          rx_st <= IDLE;
          rx_frame_err <= !rx_s2;
          rx_overrun <= rx_s2 && rx_full && !rx_pop;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_xcvr_param.sv
// tb_uart_xcvr_param: directed checks of the UART transceiver at CLK_DIV=16, FIFO_DEPTH=4.
module tb_uart_xcvr_param;
`ifdef UART_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL = 10 + PAR;
  logic clk = 1'b0, rst = 1'b1, rxd, txd, tx_valid = 1'b0, tx_ready, tx_busy;
  logic rx_valid, rx_ready = 1'b0, rx_frame_err, rx_overrun, rx_parity_err;
  logic [7:0] tx_data = 8'h00, rx_data;
  logic loop = 1'b1, rx_drv = 1'b1;
  int errors = 0, checks = 0;
  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
  assign rxd = loop ? txd : rx_drv;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rx_frame_err === 1'b1) fe_cnt++;
    if (rx_overrun === 1'b1) ov_cnt++;
    if (rx_parity_err === 1'b1) pe_cnt++;
  end
  uart_xcvr_param #(.CLK_DIV(16), .DATA_BITS(8), .FIFO_DEPTH(4), .PARITY_ODD(0)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .txd(txd), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun),
    .rx_parity_err(rx_parity_err)
  );
  function automatic logic exp_bit(input logic [7:0] w, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return w[k-1];
    if (k == 9 && PAR == 1) return ^w;
    return 1'b1;
  endfunction
  task automatic send_rx(input logic [7:0] w, input logic par, input logic stop);
    rx_drv = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = w[i];
      repeat (16) @(negedge clk);
    end
    if (PAR == 1) begin
      rx_drv = par;
      repeat (16) @(negedge clk);
    end
    rx_drv = stop;
    repeat (16) @(negedge clk);
    rx_drv = 1'b1;
    repeat (4) @(negedge clk);
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 8;
    if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd got=%b exp=1", txd); end
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
    if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_tx_busy got=%b exp=0", tx_busy); end
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b exp=0", rx_frame_err); end
    if (rx_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", rx_overrun); end
    if (rx_parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err got=%b exp=0", rx_parity_err); end
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_tx_frame;
    int fe0, ov0, pe0;
    fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
    loop = 1'b1;
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    checks += 2;
    if (txd !== 1'b1) begin errors++; $display("FAIL tx_latency_e0 txd got=%b exp=1", txd); end
    if (tx_busy !== 1'b1) begin errors++; $display("FAIL tx_busy_e0 got=%b exp=1", tx_busy); end
    @(negedge clk);
    for (int c = 0; c < FL * 16; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if (txd !== exp_bit(8'hA5, c / 16)) begin
        errors++;
        $display("FAIL tx_a5_bit cycle=%0d got=%b exp=%b", c, txd, exp_bit(8'hA5, c / 16));
      end
    end
    for (int i = 0; i < 100 && !rx_valid; i++) @(negedge clk);
    checks += 3;
    if (rx_valid !== 1'b1) begin errors++; $display("FAIL rx_a5_valid got=%b exp=1", rx_valid); end
    if (rx_data !== 8'hA5) begin errors++; $display("FAIL rx_a5_data got=%h exp=a5", rx_data); end
    if (fe_cnt != fe0 || ov_cnt != ov0 || pe_cnt != pe0) begin
      errors++;
      $display("FAIL a5_no_err_pulses got fe=%0d ov=%0d pe=%0d exp=0", fe_cnt - fe0, ov_cnt - ov0, pe_cnt - pe0);
    end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_a5_pop_empty got=%b exp=0", rx_valid); end
  endtask
  task automatic test_back_to_back;
    logic [7:0] w [3];
    w[0] = 8'h01; w[1] = 8'h02; w[2] = 8'h03;
    loop = 1'b1;
    tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      tx_data = w[i];
      checks++;
      if (tx_ready !== 1'b1) begin errors++; $display("FAIL b2b_tx_ready word=%0d got=%b exp=1", i, tx_ready); end
    end
    for (int c = 0; c < 3 * FL * 16; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) tx_valid = 1'b0;
      checks++;
      if (txd !== exp_bit(w[c / (FL * 16)], (c % (FL * 16)) / 16)) begin
        errors++;
        $display("FAIL b2b_txd cycle=%0d got=%b exp=%b", c, txd, exp_bit(w[c / (FL * 16)], (c % (FL * 16)) / 16));
      end
    end
    checks++;
    if (tx_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_last got=%b exp=1", tx_busy); end
    @(negedge clk);
    checks += 2;
    if (tx_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got=%b exp=0", tx_busy); end
    if (txd !== 1'b1) begin errors++; $display("FAIL b2b_txd_idle got=%b exp=1", txd); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== w[i]) begin
        errors++;
        $display("FAIL b2b_rx_pop%0d got=%b/%h exp=1/%h", i, rx_valid, rx_data, w[i]);
      end
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_rx_empty got=%b exp=0", rx_valid); end
  endtask
  task automatic test_glitch;
    int fe0;
    fe0 = fe_cnt;
    loop = 1'b0;
    rx_drv = 1'b0;
    repeat (6) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    checks += 2;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_rx_valid got=%b exp=0", rx_valid); end
    if (fe_cnt != fe0) begin errors++; $display("FAIL glitch_frame_err got=%0d exp=0", fe_cnt - fe0); end
    send_rx(8'h5A, ^8'h5A, 1'b1);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h5A) begin
      errors++;
      $display("FAIL glitch_rearm got=%b/%h exp=1/5a", rx_valid, rx_data);
    end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask
  task automatic test_frame_err;
    int fe0;
    fe0 = fe_cnt;
    loop = 1'b0;
    send_rx(8'h3C, ^8'h3C, 1'b0);
    repeat (20) @(negedge clk);
    checks += 2;
    if (fe_cnt != fe0 + 1) begin errors++; $display("FAIL frame_err_pulses got=%0d exp=1", fe_cnt - fe0); end
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL frame_err_rx_valid got=%b exp=0", rx_valid); end
  endtask
  task automatic test_overrun;
    int ov0;
    logic [7:0] w [5];
    w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44; w[4] = 8'h55;
    ov0 = ov_cnt;
    loop = 1'b0;
    for (int i = 0; i < 4; i++) send_rx(w[i], ^w[i], 1'b1);
    checks += 2;
    if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_rx_valid got=%b exp=1", rx_valid); end
    if (ov_cnt != ov0) begin errors++; $display("FAIL ovr_early got=%0d exp=0", ov_cnt - ov0); end
    send_rx(w[4], ^w[4], 1'b1);
    checks++;
    if (ov_cnt != ov0 + 1) begin errors++; $display("FAIL ovr_pulse got=%0d exp=1", ov_cnt - ov0); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== w[i]) begin
        errors++;
        $display("FAIL ovr_pop%0d got=%b/%h exp=1/%h", i, rx_valid, rx_data, w[i]);
      end
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_empty got=%b exp=0", rx_valid); end
  endtask
  task automatic test_reset_mid;
    int fe0, lows;
    fe0 = fe_cnt;
    lows = 0;
    loop = 1'b1;
    tx_valid = 1'b1;
    tx_data = 8'h81;
    @(negedge clk);
    tx_data = 8'h42;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (60) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks += 4;
    if (txd !== 1'b1) begin errors++; $display("FAIL rst_mid_txd got=%b exp=1", txd); end
    if (tx_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_tx_busy got=%b exp=0", tx_busy); end
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_tx_ready got=%b exp=1", tx_ready); end
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_rx_valid got=%b exp=0", rx_valid); end
    rst = 1'b0;
    for (int c = 0; c < 2 * FL * 16; c++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    checks += 3;
    if (lows != 0) begin errors++; $display("FAIL rst_mid_txd_idle low_cycles=%0d exp=0", lows); end
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_no_word got=%b exp=0", rx_valid); end
    if (fe_cnt != fe0) begin errors++; $display("FAIL rst_mid_frame_err got=%0d exp=0", fe_cnt - fe0); end
  endtask
  task automatic test_parity;
`ifdef UART_PARITY_EN
    int pe0;
    pe0 = pe_cnt;
    loop = 1'b0;
    send_rx(8'h07, 1'b0, 1'b1);
    checks += 2;
    if (pe_cnt != pe0 + 1) begin errors++; $display("FAIL parity_err_pulse got=%0d exp=1", pe_cnt - pe0); end
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL parity_dropped got=%b exp=0", rx_valid); end
    send_rx(8'h07, 1'b1, 1'b1);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h07) begin
      errors++;
      $display("FAIL parity_good got=%b/%h exp=1/07", rx_valid, rx_data);
    end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
`else
    checks++;
    if (pe_cnt != 0) begin errors++; $display("FAIL parity_err_tied got=%0d exp=0", pe_cnt); end
`endif
  endtask
  initial begin
    test_reset;
    test_tx_frame;
    test_back_to_back;
    test_glitch;
    test_frame_err;
    test_overrun;
    test_reset_mid;
    test_parity;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
